// File: rtl/fds_pkg.sv
// Shared opcodes, decode enums and constants for the fetch/decode stage.
package fds_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } aluctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } resultsrc_t;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_t;

   // sltu has no ALU code of its own and shares slt; sra shares srl.
   function automatic aluctrl_t alu_from_funct3(input logic [2:0] funct3, input logic sub);
      aluctrl_t a;
      case (funct3)
         3'b000:  a = sub ? ALU_SUB : ALU_ADD;
         3'b001:  a = ALU_SLL;
         3'b010:  a = ALU_SLT;
         3'b011:  a = ALU_SLT;
         3'b100:  a = ALU_XOR;
         3'b101:  a = ALU_SRL;
         3'b110:  a = ALU_OR;
         default: a = ALU_AND;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/fetch_decode_stage_rv_decoder.sv
// Combinational RV32I decode of the IF/ID instruction into controls and immediate.
module rv_decoder
   import fds_pkg::*;
(
   input  logic [31:0] instr,
   output logic        regwrite,
   output logic        memwrite,
   output logic        alusrc,
   output aluctrl_t    aluctrl,
   output resultsrc_t  resultsrc,
   output logic        branch,
   output logic        jump,
   output logic        illegal,
   output logic [31:0] immop
);

   imm_t imm_sel;

   always_comb begin
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      alusrc    = 1'b0;
      aluctrl   = ALU_ADD;
      resultsrc = RES_ALU;
      branch    = 1'b0;
      jump      = 1'b0;
      illegal   = 1'b0;
      imm_sel   = IMM_NONE;
      case (instr[6:0])
         OP_R: begin
            regwrite = 1'b1;
            aluctrl  = alu_from_funct3(instr[14:12], instr[30]);
         end
         OP_IALU: begin
            regwrite = 1'b1;
            alusrc   = 1'b1;
            aluctrl  = alu_from_funct3(instr[14:12], 1'b0);
            imm_sel  = IMM_I;
         end
         OP_LOAD: begin
            regwrite  = 1'b1;
            alusrc    = 1'b1;
            resultsrc = RES_MEM;
            imm_sel   = IMM_I;
         end
         OP_STORE: begin
            memwrite = 1'b1;
            alusrc   = 1'b1;
            imm_sel  = IMM_S;
         end
         OP_BRANCH: begin
            branch  = 1'b1;
            aluctrl = ALU_SUB;
            imm_sel = IMM_B;
         end
         OP_JAL: begin
            jump      = 1'b1;
            regwrite  = 1'b1;
            resultsrc = RES_PC4;
            imm_sel   = IMM_J;
         end
         OP_LUI: begin
            regwrite  = 1'b1;
            resultsrc = RES_IMM;
            imm_sel   = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (imm_sel)
         IMM_I:   immop = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   immop = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   immop = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   immop = {instr[31:12], 12'b0};
         IMM_J:   immop = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: immop = '0;
      endcase
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// PC and IF/ID pipeline register with redirect/stall priority; decode is gated by id_valid.
module fetch_decode_stage
   import fds_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_data,
   output logic                     id_valid,
   output logic [ADDRESS_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0]    id_instr,
   output logic [DATA_WIDTH-1:0]    immop,
   output logic                     regwrite,
   output logic                     memwrite,
   output logic                     alusrc,
   output logic [2:0]               aluctrl,
   output logic [1:0]               resultsrc,
   output logic                     branch,
   output logic                     jump,
   output logic                     illegal
);

   logic [ADDRESS_WIDTH-1:0] pc;

   logic       dec_regwrite, dec_memwrite, dec_alusrc;
   logic       dec_branch, dec_jump, dec_illegal;
   aluctrl_t   dec_aluctrl;
   resultsrc_t dec_resultsrc;
   logic [31:0] dec_immop;

   assign imem_addr = pc;

   // A redirect flushes even while stalled: the slot holds a wrong-path instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_instr <= DATA_WIDTH'(NOP);
      end else if (redirect) begin
         pc       <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
         id_valid <= 1'b0;
         id_instr <= DATA_WIDTH'(NOP);
      end else if (!stall) begin
         pc       <= pc + ADDRESS_WIDTH'(4);
         id_pc    <= pc;
         id_instr <= imem_data;
         id_valid <= 1'b1;
      end
   end

   rv_decoder u_dec (
      .instr     (id_instr),
      .regwrite  (dec_regwrite),
      .memwrite  (dec_memwrite),
      .alusrc    (dec_alusrc),
      .aluctrl   (dec_aluctrl),
      .resultsrc (dec_resultsrc),
      .branch    (dec_branch),
      .jump      (dec_jump),
      .illegal   (dec_illegal),
      .immop     (dec_immop)
   );

   always_comb begin
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      alusrc    = 1'b0;
      aluctrl   = 3'b000;
      resultsrc = 2'b00;
      branch    = 1'b0;
      jump      = 1'b0;
      illegal   = 1'b0;
      immop     = '0;
      if (id_valid) begin
         regwrite  = dec_regwrite;
         memwrite  = dec_memwrite;
         alusrc    = dec_alusrc;
         aluctrl   = dec_aluctrl;
         resultsrc = dec_resultsrc;
         branch    = dec_branch;
         jump      = dec_jump;
         illegal   = dec_illegal;
         immop     = dec_immop;
      end
   end

endmodule
